conway_gen_sched: RTL and testbench

Generation scheduler for the double-buffered Conway accelerator. Decides when a new generation is computed, issues start pulses to the accelerator datapath, and swaps the two grid memories' roles (source "t" vs destination "t+1") only during vertical blank, so the VGA scan never sees a half-written grid. Sits between the software register file, the VGA timing generator and the accelerator core.

---
 rtl/conway_pkg.sv | 20 ++
 rtl/conway_gen_sched_if.sv | 37 +++
 rtl/conway_frame_div.sv | 34 +++
 rtl/conway_gen_sched.sv | 173 +++++++++++++++++
 tb/tb_conway_gen_sched.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conway_pkg.sv
// conway_pkg: shared types and defaults for the Conway generation scheduler.
// Optional watchdog macro used by the scheduler: CONWAY_GEN_WDOG_EN.
package conway_pkg;

  localparam int DEF_GEN_W       = 16;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_WDOG_CYCLES = 262144;

  // m1 holds generation t (displayed) when direction is 0
  localparam logic DIR_M1_T = 1'b0;
  localparam logic DIR_M2_T = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    COMPUTE,
    WAIT_SWAP
  } state_t;

endpackage

// File: rtl/conway_gen_sched_if.sv
// conway_gen_sched_if: control/status bundle between the register file,
// VGA timing, the accelerator core and the generation scheduler.
interface conway_gen_sched_if
  import conway_pkg::*;
#(
  parameter int GEN_W = DEF_GEN_W,
  parameter int DIV_W = DEF_DIV_W
);

  logic             run;
  logic             step;
  logic [DIV_W-1:0] frames_per_gen;
  logic             vsync_start;
  logic             accel_done;
  logic             clear_status;
  logic             accel_start;
  logic             direction;
  logic             busy;
  logic [GEN_W-1:0] gen_count;
  logic             overrun;
  logic             wdog_fault;

  modport master (
    output run, step, frames_per_gen,
    output vsync_start, accel_done, clear_status,
    input  accel_start, direction, busy,
    input  gen_count, overrun, wdog_fault
  );

  modport slave (
    input  run, step, frames_per_gen,
    input  vsync_start, accel_done, clear_status,
    output accel_start, direction, busy,
    output gen_count, overrun, wdog_fault
  );

endinterface

// File: rtl/conway_frame_div.sv
// conway_frame_div: vsync counter with clear, saturation at the divisor
// and a terminal-count flag (divisor 0 behaves as 1).
module conway_frame_div
  import conway_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim;
  logic [DIV_W:0]   nxt;

  assign lim = (div == '0) ? DIV_W'(1) : div;
  assign nxt = {1'b0, cnt} + (DIV_W+1)'(1);
  assign tc  = (nxt >= {1'b0, lim});

  // count vsyncs; park at the divisor once reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= tc ? lim : nxt[DIV_W-1:0];
  end

endmodule

// File: rtl/conway_gen_sched.sv
// conway_gen_sched: starts accelerator generations and swaps buffers in vblank.
// Optional cycle watchdog on COMPUTE enabled by CONWAY_GEN_WDOG_EN.
module conway_gen_sched
  import conway_pkg::*;
#(
  parameter int GEN_W       = DEF_GEN_W,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input logic               clk,
  input logic               reset,
  conway_gen_sched_if.slave bus
);

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  state_t state, state_n;

  logic tc, fd_clr, fd_inc;
  logic start_c, swap_c, ovr_c, wdog_c, wdog_hit;
  logic vs, dn;

  logic             start_q, dir_q, busy_q;
  logic             ovr_q, wdog_q;
  logic [GEN_W-1:0] gen_q;

  assign vs = bus.vsync_start;
  assign dn = bus.accel_done;

  conway_frame_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (fd_clr),
    .inc   (fd_inc),
    .div   (bus.frames_per_gen),
    .tc    (tc)
  );

`ifdef CONWAY_GEN_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // cycles spent waiting on the accelerator
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wdog_cnt <= '0;
    else if (state == COMPUTE)
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    else
      wdog_cnt <= '0;
  end

  assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.run)
          state_n = WAIT_FRAME;
        else if (bus.step)
          state_n = COMPUTE;
      end
      WAIT_FRAME: begin
        if (!bus.run)
          state_n = IDLE;
        else if (vs && tc)
          state_n = COMPUTE;
      end
      COMPUTE: begin
        if (dn && vs)
          state_n = bus.run ? WAIT_FRAME : IDLE;
        else if (dn)
          state_n = WAIT_SWAP;
        else if (wdog_hit)
          state_n = IDLE;
      end
      WAIT_SWAP: begin
        if (vs)
          state_n = bus.run ? WAIT_FRAME : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // per-state actions: start, swap, overrun, divider control
  always_comb begin
    start_c = 1'b0;
    swap_c  = 1'b0;
    ovr_c   = 1'b0;
    wdog_c  = 1'b0;
    fd_clr  = 1'b0;
    fd_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        fd_clr  = 1'b1;
        start_c = !bus.run && bus.step;
      end
      WAIT_FRAME: begin
        if (!bus.run) begin
          fd_clr = 1'b1;
        end else if (vs) begin
          start_c = tc;
          fd_clr  = tc;
          fd_inc  = !tc;
        end
      end
      COMPUTE: begin
        if (dn && vs) begin
          swap_c = 1'b1;
        end else if (!dn) begin
          fd_inc = vs;
          ovr_c  = vs && tc;
          wdog_c = wdog_hit;
        end
      end
      WAIT_SWAP: swap_c = vs;
      default: ;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      dir_q   <= DIR_M1_T;
      busy_q  <= 1'b0;
      gen_q   <= '0;
      ovr_q   <= 1'b0;
      wdog_q  <= 1'b0;
    end else begin
      start_q <= start_c;
      if (start_c)
        busy_q <= 1'b1;
      else if (swap_c || wdog_c)
        busy_q <= 1'b0;
      if (swap_c) begin
        dir_q <= ~dir_q;
        gen_q <= gen_q + GEN_W'(1);
      end
      if (ovr_c)
        ovr_q <= 1'b1;
      else if (bus.clear_status)
        ovr_q <= 1'b0;
      if (wdog_c)
        wdog_q <= 1'b1;
      else if (bus.clear_status)
        wdog_q <= 1'b0;
    end
  end

  assign bus.accel_start = start_q;
  assign bus.direction   = dir_q;
  assign bus.busy        = busy_q;
  assign bus.gen_count   = gen_q;
  assign bus.overrun     = ovr_q;
  assign bus.wdog_fault  = wdog_q;

endmodule

// File: tb/tb_conway_gen_sched.sv
// tb_conway_gen_sched: directed scenarios plus randomized run against
// a behavioural scheduler model.
module tb_conway_gen_sched;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conway_gen_sched_if bus ();

  conway_gen_sched #(.WDOG_CYCLES(1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  // behavioural model state
  bit m_busy, m_done, m_armed, m_dir, m_ovr, m_start;
  int m_frames, m_gen;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.run          = 1'b0;
    bus.step         = 1'b0;
    bus.vsync_start  = 1'b0;
    bus.accel_done   = 1'b0;
    bus.clear_status = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    m_busy = 0; m_done = 0; m_armed = 0;
    m_dir = 0; m_ovr = 0; m_start = 0;
    m_frames = 0; m_gen = 0;
  endtask

  task automatic vs();
    bus.vsync_start = 1'b1;
    cyc(1);
    bus.vsync_start = 1'b0;
  endtask

  task automatic done();
    bus.accel_done = 1'b1;
    cyc(1);
    bus.accel_done = 1'b0;
  endtask

  task automatic model_step(input bit run, input bit step, input bit v,
                            input bit dn, input bit clr, input int fpg);
    int lim;
    bit set_ovr, swap;
    lim = (fpg == 0) ? 1 : fpg;
    set_ovr = 0;
    swap = 0;
    m_start = 0;
    if (!m_busy) begin
      if (!m_armed) begin
        if (run) begin
          m_armed = 1;
          m_frames = 0;
        end else if (step) begin
          m_start = 1;
        end
      end else if (!run) begin
        m_armed = 0;
      end else if (v) begin
        if (m_frames + 1 >= lim) m_start = 1;
        else m_frames++;
      end
      if (m_start) begin
        m_busy = 1; m_done = 0; m_armed = 0; m_frames = 0;
      end
    end else if (!m_done) begin
      if (dn && v) swap = 1;
      else if (dn) m_done = 1;
      else if (v) begin
        if (m_frames + 1 >= lim) begin
          set_ovr = 1;
          m_frames = lim;
        end else m_frames++;
      end
    end else if (v) begin
      swap = 1;
    end
    if (swap) begin
      m_dir = !m_dir;
      m_gen = (m_gen + 1) % 65536;
      m_busy = 0;
      m_armed = run;
    end
    if (set_ovr) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    idle_inputs();
    bus.frames_per_gen = 8'd1;
    reset = 1'b1;
    cyc(2);
    got = {bus.accel_start, bus.direction, bus.busy, bus.gen_count,
           bus.overrun, bus.wdog_fault};
    checks++;
    if (got !== 21'h0) begin
      errs++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    reset = 1'b0;
    cyc(2);
    checks++;
    if (bus.accel_start !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: start=%b busy=%b expected 0 0",
               bus.accel_start, bus.busy);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    bus.frames_per_gen = 8'd1;
    bus.run = 1'b1;
    cyc(3);
    for (int i = 1; i <= 3; i++) begin
      vs();
      checks++;
      if (bus.accel_start !== 1'b1 || bus.busy !== 1'b1) begin
        errs++;
        $display("FAIL free_start[%0d]: start=%b busy=%b expected 1 1",
                 i, bus.accel_start, bus.busy);
      end
      cyc(1);
      checks++;
      if (bus.accel_start !== 1'b0) begin
        errs++;
        $display("FAIL free_pulse[%0d]: start=%b expected 0",
                 i, bus.accel_start);
      end
      cyc(99);
      done();
      cyc(5);
      vs();
      checks++;
      if (bus.direction !== 1'(i % 2) || bus.gen_count !== 16'(i) ||
          bus.busy !== 1'b0 || bus.accel_start !== 1'b0) begin
        errs++;
        $display("FAIL free_swap[%0d]: dir=%b gen=%0d busy=%b start=%b expected %0d %0d 0 0",
                 i, bus.direction, bus.gen_count, bus.busy,
                 bus.accel_start, i % 2, i);
      end
      cyc(5);
    end
  endtask

  task automatic test_div3();
    bit exp;
    do_reset();
    bus.frames_per_gen = 8'd3;
    bus.run = 1'b1;
    cyc(2);
    for (int v = 1; v <= 7; v++) begin
      vs();
      exp = (v == 3 || v == 7);
      checks++;
      if (bus.accel_start !== exp) begin
        errs++;
        $display("FAIL div3_start[v%0d]: start=%b expected %b",
                 v, bus.accel_start, exp);
      end
      if (v == 4) begin
        checks++;
        if (bus.gen_count !== 16'd1 || bus.direction !== 1'b1) begin
          errs++;
          $display("FAIL div3_swap: gen=%0d dir=%b expected 1 1",
                   bus.gen_count, bus.direction);
        end
      end
      if (v == 3) begin
        cyc(4);
        done();
      end
      cyc(6);
    end
  endtask

  task automatic test_step();
    do_reset();
    bus.frames_per_gen = 8'd1;
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    checks++;
    if (bus.accel_start !== 1'b1 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL step_start: start=%b busy=%b expected 1 1",
               bus.accel_start, bus.busy);
    end
    cyc(10);
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    checks++;
    if (bus.accel_start !== 1'b0) begin
      errs++;
      $display("FAIL step_ignored: start=%b expected 0", bus.accel_start);
    end
    done();
    cyc(3);
    vs();
    checks++;
    if (bus.gen_count !== 16'd1 || bus.direction !== 1'b1 ||
        bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL step_swap: gen=%0d dir=%b busy=%b expected 1 1 0",
               bus.gen_count, bus.direction, bus.busy);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(4);
      vs();
      checks++;
      if (bus.accel_start !== 1'b0 || bus.busy !== 1'b0) begin
        errs++;
        $display("FAIL step_quiet[%0d]: start=%b busy=%b expected 0 0",
                 i, bus.accel_start, bus.busy);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.frames_per_gen = 8'd1;
    bus.run = 1'b1;
    cyc(2);
    vs();
    cyc(5);
    vs();
    checks++;
    if (bus.overrun !== 1'b1) begin
      errs++;
      $display("FAIL ovr_set: overrun=%b expected 1", bus.overrun);
    end
    cyc(5);
    vs();
    cyc(5);
    done();
    cyc(3);
    checks++;
    if (bus.direction !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL ovr_noswap: dir=%b busy=%b expected 0 1",
               bus.direction, bus.busy);
    end
    vs();
    checks++;
    if (bus.direction !== 1'b1 || bus.gen_count !== 16'd1 ||
        bus.overrun !== 1'b1) begin
      errs++;
      $display("FAIL ovr_swap: dir=%b gen=%0d ovr=%b expected 1 1 1",
               bus.direction, bus.gen_count, bus.overrun);
    end
    bus.clear_status = 1'b1;
    cyc(1);
    bus.clear_status = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errs++;
      $display("FAIL ovr_clear: overrun=%b expected 0", bus.overrun);
    end
  endtask

  task automatic test_same_cycle();
    logic [20:0] got;
    do_reset();
    bus.frames_per_gen = 8'd1;
    bus.run = 1'b1;
    cyc(2);
    vs();
    cyc(20);
    bus.vsync_start = 1'b1;
    bus.accel_done = 1'b1;
    cyc(1);
    bus.vsync_start = 1'b0;
    bus.accel_done = 1'b0;
    checks++;
    if (bus.direction !== 1'b1 || bus.gen_count !== 16'd1 ||
        bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL same_swap: dir=%b gen=%0d busy=%b expected 1 1 0",
               bus.direction, bus.gen_count, bus.busy);
    end
    cyc(3);
    vs();
    checks++;
    if (bus.accel_start !== 1'b1) begin
      errs++;
      $display("FAIL same_restart: start=%b expected 1", bus.accel_start);
    end
    cyc(5);
    reset = 1'b1;
    #2;
    got = {bus.accel_start, bus.direction, bus.busy, bus.gen_count,
           bus.overrun, bus.wdog_fault};
    checks++;
    if (got !== 21'h0) begin
      errs++;
      $display("FAIL mid_reset: got %h expected 0", got);
    end
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

`ifdef CONWAY_GEN_WDOG_EN
  task automatic test_wdog();
    do_reset();
    bus.frames_per_gen = 8'd1;
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    cyc(999);
    checks++;
    if (bus.wdog_fault !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL wdog_early: wdog=%b busy=%b expected 0 1",
               bus.wdog_fault, bus.busy);
    end
    cyc(1);
    checks++;
    if (bus.wdog_fault !== 1'b1 || bus.busy !== 1'b0 ||
        bus.direction !== 1'b0 || bus.gen_count !== 16'd0) begin
      errs++;
      $display("FAIL wdog_fire: wdog=%b busy=%b dir=%b gen=%0d expected 1 0 0 0",
               bus.wdog_fault, bus.busy, bus.direction, bus.gen_count);
    end
  endtask
`endif

  task automatic test_random();
    int vs_cnt, pend, fails;
    logic [20:0] got, exp;
    do_reset();
    bus.frames_per_gen = 8'd1;
    vs_cnt = 5;
    pend = 0;
    fails = 0;
    for (int n = 0; n < 4000 && fails < 10; n++) begin
      bus.vsync_start = (vs_cnt == 0);
      vs_cnt = (vs_cnt == 0) ? $urandom_range(6, 30) : vs_cnt - 1;
      bus.accel_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) bus.accel_done = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        bus.accel_done = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) bus.run = ~bus.run;
      bus.step = ($urandom_range(0, 19) == 0);
      bus.clear_status = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0)
        bus.frames_per_gen = 8'($urandom_range(0, 3));
      model_step(bus.run, bus.step, bus.vsync_start, bus.accel_done,
                 bus.clear_status, int'(bus.frames_per_gen));
      cyc(1);
      got = {bus.accel_start, bus.direction, bus.busy, bus.gen_count,
             bus.overrun, bus.wdog_fault};
      exp = {m_start, m_dir, m_busy, 16'(m_gen), m_ovr, 1'b0};
      checks++;
      if (got !== exp) begin
        errs++;
        fails++;
        $display("FAIL random[%0d]: got %h expected %h", n, got, exp);
      end
      if (bus.accel_start === 1'b1) pend = $urandom_range(1, 60);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_div3();
    test_step();
    test_overrun();
    test_same_cycle();
`ifdef CONWAY_GEN_WDOG_EN
    test_wdog();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
